// File: rtl/gpu_isa_pkg.sv
// gpu_isa_pkg: shared ISA encoding (opcodes, instruction word) for tiny_gpu_core.
package gpu_isa_pkg;
    localparam int NUM_REGS = 8;
    typedef enum logic [3:0] {
        NOP = 4'd0,
        ADD = 4'd1,
        SUB = 4'd2,
        MOV = 4'd3,
        LDR = 4'd4,
        STR = 4'd5,
        BEQ = 4'd6,
        JMP = 4'd7
    } opcode_t;
    typedef struct packed {
        opcode_t     opcode;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [15:0] imm;
    } instruction_t;
    function automatic logic writes_rd(opcode_t op);
        return op inside {ADD, SUB, MOV, LDR};
    endfunction
endpackage

// File: rtl/gpu_lane_alu.sv
// gpu_lane_alu: per-lane add/subtract and equality compare.
module gpu_lane_alu #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  sub_i,
    output logic [DATA_WIDTH-1:0] res_o,
    output logic                  eq_o
);
    always_comb begin
        res_o = sub_i ? a_i - b_i : a_i + b_i;
        eq_o  = a_i == b_i;
    end
endmodule

// File: rtl/tiny_gpu_core.sv
// tiny_gpu_core: SIMT core, NUM_THREADS lanes sharing one PC, divergence tracked by exec_mask.
// Define TINY_GPU_R0_ZERO_EN to hardwire R0 to zero in every lane.
module tiny_gpu_core
    import gpu_isa_pkg::*;
#(
    parameter int NUM_THREADS = 4,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  instruction_t           instr_in,
    input  logic [DATA_WIDTH-1:0]  mem_rdata [NUM_THREADS],
    output logic [DATA_WIDTH-1:0]  mem_addr  [NUM_THREADS],
    output logic [DATA_WIDTH-1:0]  mem_wdata [NUM_THREADS],
    output logic [NUM_THREADS-1:0] mem_we,
    output logic [15:0]            pc_out
);
    logic [DATA_WIDTH-1:0]  reg_file [NUM_THREADS][NUM_REGS];
    logic [NUM_THREADS-1:0] exec_mask, mask_d, alu_eq, eq, lane_we;
    logic [15:0]            pc_q, pc_d;
    logic [DATA_WIDTH-1:0]  imm_w;
    logic [DATA_WIDTH-1:0]  rs1_v [NUM_THREADS];
    logic [DATA_WIDTH-1:0]  rs2_v [NUM_THREADS];
    logic [DATA_WIDTH-1:0]  alu_res [NUM_THREADS];
    logic [DATA_WIDTH-1:0]  wr_data [NUM_THREADS];
    logic                   rd_ok, beq_hit;

    assign imm_w  = DATA_WIDTH'(instr_in.imm);
    assign pc_out = pc_q;
`ifdef TINY_GPU_R0_ZERO_EN
    // R0 stays at its reset value of zero because it is never written.
    assign rd_ok = instr_in.rd != 3'd0;
`else
    assign rd_ok = 1'b1;
`endif

    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_lane
        assign rs1_v[t]     = reg_file[t][instr_in.rs1];
        assign rs2_v[t]     = reg_file[t][instr_in.rs2];
        assign mem_addr[t]  = rs1_v[t] + imm_w;
        assign mem_wdata[t] = rs2_v[t];
        assign wr_data[t]   = instr_in.opcode == MOV ? imm_w :
                              instr_in.opcode == LDR ? mem_rdata[t] : alu_res[t];
        gpu_lane_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
            .a_i  (rs1_v[t]),
            .b_i  (rs2_v[t]),
            .sub_i(instr_in.opcode == SUB),
            .res_o(alu_res[t]),
            .eq_o (alu_eq[t])
        );
    end

    always_comb begin
        eq      = alu_eq & exec_mask;
        beq_hit = instr_in.opcode == BEQ && |eq;
        pc_d    = beq_hit || instr_in.opcode == JMP ? instr_in.imm : pc_q + 16'd1;
        mask_d  = instr_in.opcode == JMP ? '1 : beq_hit ? eq : exec_mask;
        lane_we = writes_rd(instr_in.opcode) && rd_ok ? exec_mask : '0;
        mem_we  = instr_in.opcode == STR && !rst_n ? exec_mask : '0;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            pc_q      <= '0;
            exec_mask <= '1;
            for (int i = 0; i < NUM_THREADS; i++)
                for (int j = 0; j < NUM_REGS; j++)
                    reg_file[i][j] <= '0;
        end else begin
            pc_q      <= pc_d;
            exec_mask <= mask_d;
            for (int i = 0; i < NUM_THREADS; i++)
                if (lane_we[i]) reg_file[i][instr_in.rd] <= wr_data[i];
        end
    end
endmodule

// File: tb/tb_tiny_gpu_core.sv
// tb_tiny_gpu_core: directed and randomized checks of tiny_gpu_core against a lane-level model.
module tb_tiny_gpu_core;
    import gpu_isa_pkg::*;
    localparam int NT = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    instruction_t  instr_in;
    logic [DW-1:0] mem_rdata [NT];
    logic [DW-1:0] mem_addr  [NT];
    logic [DW-1:0] mem_wdata [NT];
    logic [NT-1:0] mem_we;
    logic [15:0]   pc_out;
    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_reg [NT][8];
    logic [NT-1:0] m_mask;
    logic [15:0]   m_pc;

    always #5 clk = ~clk;

    tiny_gpu_core #(.NUM_THREADS(NT), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .instr_in (instr_in),
        .mem_rdata(mem_rdata),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .pc_out   (pc_out)
    );

    function automatic instruction_t mk(opcode_t op, int rd, int rs1, int rs2, int imm);
        instruction_t i;
        i.opcode = op;
        i.rd     = 3'(rd);
        i.rs1    = 3'(rs1);
        i.rs2    = 3'(rs2);
        i.imm    = 16'(imm);
        return i;
    endfunction

    // Architectural effect of the instruction presented this cycle.
    task automatic model_step();
        instruction_t  i = instr_in;
        logic [NT-1:0] hit = '0;
        if (rst_n) begin
            m_pc   = 16'd0;
            m_mask = '1;
            for (int t = 0; t < NT; t++)
                for (int r = 0; r < 8; r++) m_reg[t][r] = '0;
            return;
        end
        m_pc = m_pc + 16'd1;
        for (int t = 0; t < NT; t++) begin
            if (!m_mask[t]) continue;
            case (i.opcode)
                ADD: m_reg[t][i.rd] = m_reg[t][i.rs1] + m_reg[t][i.rs2];
                SUB: m_reg[t][i.rd] = m_reg[t][i.rs1] - m_reg[t][i.rs2];
                MOV: m_reg[t][i.rd] = i.imm;
                LDR: m_reg[t][i.rd] = mem_rdata[t];
                BEQ: hit[t] = m_reg[t][i.rs1] == m_reg[t][i.rs2];
                default: ;
            endcase
`ifdef TINY_GPU_R0_ZERO_EN
            m_reg[t][0] = '0;
`endif
        end
        if (i.opcode == BEQ && hit != '0) begin
            m_mask = hit;
            m_pc   = i.imm;
        end
        if (i.opcode == JMP) begin
            m_mask = '1;
            m_pc   = i.imm;
        end
    endtask

    task automatic drive(input instruction_t ins, input logic r);
        @(negedge clk);
        rst_n    = r;
        instr_in = ins;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            drive(mk(STR, 1, 1, 1, 0), 1'b1);
            checks++;
            if (mem_we !== '0) begin
                errors++;
                $display("FAIL reset_we cyc%0d got %b exp 0000", c, mem_we);
            end
            tick();
        end
        checks++;
        if (pc_out !== 16'd0) begin errors++; $display("FAIL reset_pc got %h exp 0000", pc_out); end
        checks++;
        if (dut.exec_mask !== 4'b1111) begin errors++; $display("FAIL reset_mask got %b exp 1111", dut.exec_mask); end
        for (int t = 0; t < NT; t++)
            for (int r = 0; r < 8; r++) begin
                checks++;
                if (dut.reg_file[t][r] !== '0) begin
                    errors++;
                    $display("FAIL reset_reg lane%0d r%0d got %h exp 0", t, r, dut.reg_file[t][r]);
                end
            end
    endtask

    task automatic test_directed();
        for (int t = 0; t < NT; t++) mem_rdata[t] = 16'(10 + t);
        drive(mk(LDR, 1, 0, 0, 0), 1'b0);
        tick();
        for (int t = 0; t < NT; t++) begin
            checks++;
            if (dut.reg_file[t][1] !== 16'(10 + t)) begin
                errors++;
                $display("FAIL ldr_r1 lane%0d got %0d exp %0d", t, dut.reg_file[t][1], 10 + t);
            end
        end
        checks++;
        if (pc_out !== 16'd1) begin errors++; $display("FAIL ldr_pc got %0d exp 1", pc_out); end
        drive(mk(MOV, 2, 0, 0, 11), 1'b0);
        tick();
        for (int t = 0; t < NT; t++) begin
            checks++;
            if (dut.reg_file[t][2] !== 16'd11) begin
                errors++;
                $display("FAIL mov_r2 lane%0d got %0d exp 11", t, dut.reg_file[t][2]);
            end
        end
        checks++;
        if (pc_out !== 16'd2) begin errors++; $display("FAIL mov_pc got %0d exp 2", pc_out); end
        drive(mk(BEQ, 0, 1, 2, 3), 1'b0);
        tick();
        checks++;
        if (dut.exec_mask !== 4'b0010 || pc_out !== 16'd3) begin
            errors++;
            $display("FAIL beq_div got mask %b pc %0d exp 0010 3", dut.exec_mask, pc_out);
        end
        drive(mk(ADD, 3, 1, 2, 0), 1'b0);
        tick();
        for (int t = 0; t < NT; t++) begin
            checks++;
            if (dut.reg_file[t][3] !== (t == 1 ? 16'd22 : 16'd0)) begin
                errors++;
                $display("FAIL add_r3 lane%0d got %0d exp %0d", t, dut.reg_file[t][3], t == 1 ? 22 : 0);
            end
        end
        checks++;
        if (pc_out !== 16'd4) begin errors++; $display("FAIL add_pc got %0d exp 4", pc_out); end
        drive(mk(JMP, 0, 0, 0, 5), 1'b0);
        tick();
        checks++;
        if (dut.exec_mask !== 4'b1111 || pc_out !== 16'd5) begin
            errors++;
            $display("FAIL jmp got mask %b pc %0d exp 1111 5", dut.exec_mask, pc_out);
        end
        for (int k = 6; k <= 7; k++) begin
            drive(mk(NOP, 0, 0, 0, 0), 1'b0);
            tick();
            checks++;
            if (pc_out !== 16'(k)) begin errors++; $display("FAIL nop_pc got %0d exp %0d", pc_out, k); end
        end
    endtask

    task automatic test_store_masked();
        drive(mk(BEQ, 0, 1, 2, 20), 1'b0);
        tick();
        drive(mk(STR, 0, 1, 3, 5), 1'b0);
        checks++;
        if (mem_we !== 4'b0010) begin errors++; $display("FAIL str_we got %b exp 0010", mem_we); end
        checks++;
        if (mem_wdata[1] !== 16'd22) begin errors++; $display("FAIL str_wdata got %0d exp 22", mem_wdata[1]); end
        checks++;
        if (mem_addr[1] !== 16'd16) begin errors++; $display("FAIL str_addr got %0d exp 16", mem_addr[1]); end
        tick();
        drive(mk(NOP, 0, 0, 0, 0), 1'b0);
        checks++;
        if (mem_we !== '0) begin errors++; $display("FAIL str_we_drop got %b exp 0000", mem_we); end
        tick();
        drive(mk(BEQ, 0, 1, 3, 40), 1'b0);
        tick();
        checks++;
        if (dut.exec_mask !== 4'b0010 || pc_out !== 16'd23) begin
            errors++;
            $display("FAIL beq_none got mask %b pc %0d exp 0010 23", dut.exec_mask, pc_out);
        end
        drive(mk(MOV, 5, 0, 0, 99), 1'b0);
        tick();
        checks++;
        if (dut.reg_file[0][5] !== 16'd0 || dut.reg_file[1][5] !== 16'd99) begin
            errors++;
            $display("FAIL masked_mov got %0d/%0d exp 0/99", dut.reg_file[0][5], dut.reg_file[1][5]);
        end
        drive(mk(JMP, 0, 0, 0, 0), 1'b0);
        tick();
    endtask

    task automatic test_random();
        instruction_t  ins;
        logic [NT-1:0] exp_we;
        for (int c = 0; c < 400; c++) begin
            ins.opcode = opcode_t'(4'($urandom_range(0, 9)));
            ins.rd     = 3'($urandom);
            ins.rs1    = 3'($urandom);
            ins.rs2    = 3'($urandom);
            ins.imm    = $urandom_range(0, 1) == 1 ? 16'($urandom_range(0, 3)) : 16'($urandom);
            for (int t = 0; t < NT; t++) mem_rdata[t] = 16'($urandom_range(0, 3));
            drive(ins, 1'b0);
            for (int t = 0; t < NT; t++) begin
                exp_we[t] = ins.opcode == STR && m_mask[t];
                checks++;
                if (mem_addr[t] !== m_reg[t][ins.rs1] + ins.imm || mem_wdata[t] !== m_reg[t][ins.rs2]) begin
                    errors++;
                    $display("FAIL rnd_mem cyc%0d lane%0d got addr %h wdata %h exp %h %h", c, t,
                             mem_addr[t], mem_wdata[t], m_reg[t][ins.rs1] + ins.imm, m_reg[t][ins.rs2]);
                end
            end
            checks++;
            if (mem_we !== exp_we) begin errors++; $display("FAIL rnd_we cyc%0d got %b exp %b", c, mem_we, exp_we); end
            tick();
            checks++;
            if (pc_out !== m_pc || dut.exec_mask !== m_mask) begin
                errors++;
                $display("FAIL rnd_ctl cyc%0d got pc %h mask %b exp %h %b", c, pc_out, dut.exec_mask, m_pc, m_mask);
            end
            for (int t = 0; t < NT; t++)
                for (int r = 0; r < 8; r++) begin
                    checks++;
                    if (dut.reg_file[t][r] !== m_reg[t][r]) begin
                        errors++;
                        $display("FAIL rnd_reg cyc%0d lane%0d r%0d got %h exp %h", c, t, r, dut.reg_file[t][r], m_reg[t][r]);
                    end
                end
        end
    endtask

    task automatic test_reset_mid();
        drive(mk(STR, 0, 1, 2, 0), 1'b1);
        checks++;
        if (mem_we !== '0) begin errors++; $display("FAIL mid_rst_we got %b exp 0000", mem_we); end
        tick();
        drive(mk(MOV, 1, 0, 0, 7), 1'b1);
        tick();
        for (int t = 0; t < NT; t++) begin
            checks++;
            if (dut.reg_file[t][1] !== '0) begin
                errors++;
                $display("FAIL mid_rst_reg lane%0d got %h exp 0", t, dut.reg_file[t][1]);
            end
        end
        checks++;
        if (pc_out !== 16'd0 || dut.exec_mask !== 4'b1111) begin
            errors++;
            $display("FAIL mid_rst_ctl got pc %h mask %b exp 0000 1111", pc_out, dut.exec_mask);
        end
        drive(mk(MOV, 1, 0, 0, 7), 1'b0);
        tick();
        checks++;
        if (pc_out !== 16'd1 || dut.reg_file[2][1] !== 16'd7) begin
            errors++;
            $display("FAIL post_rst got pc %0d r1 %0d exp 1 7", pc_out, dut.reg_file[2][1]);
        end
    endtask

    initial begin
        instr_in = mk(NOP, 0, 0, 0, 0);
        for (int t = 0; t < NT; t++) mem_rdata[t] = '0;
        test_reset();
        test_directed();
        test_store_masked();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tiny_gpu_core.md
TINY_GPU_CORE -- requirements
Module: tiny_gpu_core

Interface
REQ-001 SHALL have parameter NUM_THREADS, default 4, number of SIMT lanes.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, lane data/address width.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, reset; synchronous, active-high (asserted = 1).
REQ-005 SHALL have port instr_in, input, instruction_t, instruction at pc_out, valid combinationally in the same cycle.
REQ-006 SHALL have port mem_rdata, input, unpacked [NUM_THREADS] x DATA_WIDTH, per-lane load data, valid combinationally.
REQ-007 SHALL have port mem_addr, output, [NUM_THREADS] x DATA_WIDTH, per-lane address.
REQ-008 SHALL have port mem_wdata, output, [NUM_THREADS] x DATA_WIDTH, per-lane store data.
REQ-009 SHALL have port mem_we, output, [NUM_THREADS] x 1, per-lane write enable.
REQ-010 SHALL have port pc_out, output, 16 bits, current shared program counter.

Function
REQ-011 SHALL hold reg_file[NUM_THREADS][8] of DATA_WIDTH, plus a NUM_THREADS-bit exec_mask; both names hierarchically visible.
REQ-012 SHALL execute one instruction per clock, with no stalls; PC <= PC+1 unless branch/jump, wrapping 0xFFFF -> 0.
REQ-013 SHALL, for ADD/SUB, write rd <= rs1 +/- rs2 (modulo 2^DATA_WIDTH) in lanes with exec_mask=1 only.
REQ-014 SHALL, for MOV, write rd <= imm (low DATA_WIDTH bits) in active lanes.
REQ-015 SHALL drive mem_addr[t] = reg[t][rs1] + imm combinationally for all opcodes.
REQ-016 SHALL, for LDR, write rd <= mem_rdata[t] in active lanes at the same edge.
REQ-017 SHALL drive mem_wdata[t] = reg[t][rs2], and mem_we[t] = (opcode==STR) & exec_mask[t] & ~rst_n-asserted; otherwise 0.
REQ-018 SHALL, for BEQ, compute eq[t] = (reg[t][rs1]==reg[t][rs2]) & exec_mask[t]; if any eq: exec_mask <= eq, PC <= imm; if none: mask unchanged, PC <= PC+1.
REQ-019 SHALL, for JMP, set PC <= imm and exec_mask <= all ones (reconvergence).
REQ-020 SHALL treat NOP and undefined opcodes as no state change except PC+1.
REQ-021 SHALL never write a register in an inactive lane.

Reset
REQ-022 SHALL, while rst_n=1 at a rising edge, set PC=0, exec_mask=all ones, all registers=0.
REQ-023 SHALL suppress all register writes and mem_we during reset; reset mid-program overrides any instruction in that cycle.

Configuration
REQ-024 SHALL, with macro TINY_GPU_R0_ZERO_EN defined, hardwire R0 of every lane to 0 (reads 0, writes ignored).
REQ-025 SHALL, without TINY_GPU_R0_ZERO_EN, treat R0 as an ordinary writable register (reset 0).

Structure
REQ-026 SHALL take opcode_t (4-bit enum: NOP=0, ADD=1, SUB=2, MOV=3, LDR=4, STR=5, BEQ=6, JMP=7) and instruction_t (packed: opcode, rd[2:0], rs1[2:0], rs2[2:0], imm[15:0]) from shared package gpu_isa_pkg, with NUM_REGS=8.
REQ-027 SHALL keep reg_file, exec_mask and PC in tiny_gpu_core; a per-lane combinational sub-module gpu_lane_alu (ADD/SUB/compare) is permitted.

Verification
REQ-028 Reset 2 cycles, then PC0 LDR rd=1 rs1=0 with mem_rdata[t]=t+10 -> R1 = 10,11,12,13; PC=1.
REQ-029 PC1 MOV rd=2 imm=11 -> R2 = 11 in all lanes; PC=2.
REQ-030 PC2 BEQ rs1=1 rs2=2 imm=3 -> exec_mask=0010, PC=3.
REQ-031 PC3 ADD rd=3 rs1=1 rs2=2 -> R3 = 0,22,0,0; PC=4; then PC4 JMP imm=5 -> mask=1111, PC=5, then NOPs advance PC 6,7,...
REQ-032 STR with mask=0010 -> mem_we=0010 for one cycle, mem_wdata[1]=reg[1][rs2]; BEQ with no matching lane -> mask unchanged, PC+1.
